// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer.
// Holds the operation codes, the controller state encoding and a
// helper that sizes the iteration counter from the operand width.
package hilo_muldiv_sequencer_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  // Counter width able to hold 0..width-1 (never narrower than one bit).
  function automatic int counterWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// Execute-stage bundle between the pipeline and the Hi/Lo sequencer.
// master : pipeline side (drives Start/Op/A/B/Abort/ReadHiLo).
// slave  : sequencer side (drives Hi/Lo/Busy/Done/Stall).
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Abort;
  logic             ReadHiLo;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start, Op, A, B, Abort, ReadHiLo,
    input  Hi, Lo, Busy, Done, Stall
  );

  modport slave (
    input  Start, Op, A, B, Abort, ReadHiLo,
    output Hi, Lo, Busy, Done, Stall
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_muldiv_iter_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one
// restoring-divide step per asserted step cycle.
// Ports: clk/rst_n, load (capture magnitudes), step (one iteration),
// isDiv (mode, captured on load), opA/opB (magnitudes of A/B),
// accHi/accLo (product high/low, or remainder/quotient).
module hilo_muldiv_sequencer_muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] accHi,
  output logic [WIDTH-1:0] accLo
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;
  logic             div_r;
  logic [WIDTH:0]   mulSum_s;
  logic [WIDTH-1:0] remShift_s;
  logic             fits_s;
  logic [WIDTH-1:0] nextHi_s;
  logic [WIDTH-1:0] nextLo_s;

  // One iteration: shift-add for multiply, trial subtract for divide.
  always_comb begin
    mulSum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    // hi_r[WIDTH-1] is the bit shifted out; if set, the shifted value
    // exceeds any WIDTH-bit divisor, and the wrapped difference is exact.
    remShift_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
    fits_s     = hi_r[WIDTH-1] | (remShift_s >= opnd_r);
    nextHi_s   = hi_r;
    nextLo_s   = lo_r;
    if (div_r) begin
      if (fits_s) begin
        nextHi_s = remShift_s - opnd_r;
        nextLo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nextHi_s = remShift_s;
        nextLo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi_s = mulSum_s[WIDTH:1];
      nextLo_s = {mulSum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      div_r  <= 1'b0;
    end else if (load) begin
      hi_r   <= {WIDTH{1'b0}};
      div_r  <= isDiv;
      lo_r   <= isDiv ? opA : opB;
      opnd_r <= isDiv ? opB : opA;
    end else if (step) begin
      hi_r <= nextHi_s;
      lo_r <= nextLo_s;
    end
  end

  assign accHi = hi_r;
  assign accLo = lo_r;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Hi/Lo multiply/divide sequencer for the Execute stage.
// Ports: Clk, Reset_n (async active-low) and the slave side of
// hilo_muldiv_sequencer_if (Start/Op/A/B/Abort/ReadHiLo in,
// Hi/Lo/Busy/Done/Stall out). Owns the FSM, iteration counter,
// sign flags, Hi/Lo registers and the pipeline stall.
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  hilo_muldiv_sequencer_if.slave  bus
);

  localparam int CW = counterWidth(WIDTH);

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  state_e             state_r, nextState_s;
  logic [CW-1:0]      count_r;
  logic [2:0]         op_r;
  logic               negRes_r, negRem_r, divZero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;
  logic               loadCore_s, stepCore_s, commit_s, moveHi_s, moveLo_s;
  logic               signA_s, signB_s;
  logic [WIDTH-1:0]   coreA_s, coreB_s, coreHi_s, coreLo_s;
  logic [2*WIDTH-1:0] signedProd_s, mulResult_s, commitVal_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Next-state and control strobes.
  always_comb begin
    nextState_s = state_r;
    loadCore_s  = 1'b0;
    stepCore_s  = 1'b0;
    commit_s    = 1'b0;
    moveHi_s    = 1'b0;
    moveLo_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.Start && !bus.Abort) begin
          if (bus.Op == OP_MTHI) begin
            moveHi_s = 1'b1;
          end else if (bus.Op == OP_MTLO) begin
            moveLo_s = 1'b1;
          end else begin
            loadCore_s  = 1'b1;
            nextState_s = S_CALC;
          end
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.Abort) begin
          nextState_s = S_IDLE;
        end else begin
          stepCore_s  = 1'b1;
          nextState_s = (count_r == CW'(WIDTH - 1)) ? S_FIXUP : S_CALC;
        end
      end
      S_FIXUP: begin
        if (bus.Abort) begin
          nextState_s = S_IDLE;
        end else begin
          commit_s    = 1'b1;
          nextState_s = S_IDLE;
        end
      end
      default: nextState_s = S_IDLE;
    endcase
  end

  // Signed ops run on magnitudes; the signs are re-applied at FIXUP.
  always_comb begin
    signA_s = isSignedOp(bus.Op) & bus.A[WIDTH-1];
    signB_s = isSignedOp(bus.Op) & bus.B[WIDTH-1];
    coreA_s = signA_s ? negate(bus.A) : bus.A;
    coreB_s = signB_s ? negate(bus.B) : bus.B;
  end

  hilo_muldiv_sequencer_muldiv_iter_core #(.WIDTH(WIDTH)) uCore (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (loadCore_s),
    .step  (stepCore_s),
    .isDiv (isDivOp(bus.Op)),
    .opA   (coreA_s),
    .opB   (coreB_s),
    .accHi (coreHi_s),
    .accLo (coreLo_s)
  );

  // Sign fix-up and MADD/MSUB accumulation against the current Hi/Lo.
  always_comb begin
    signedProd_s = negRes_r ? ({(2*WIDTH){1'b0}} - {coreHi_s, coreLo_s})
                            : {coreHi_s, coreLo_s};
    case (op_r)
      OP_MADD: mulResult_s = {hi_r, lo_r} + signedProd_s;
      OP_MSUB: mulResult_s = {hi_r, lo_r} - signedProd_s;
      default: mulResult_s = signedProd_s;
    endcase
    // Divide by zero: the remainder path already yields A, only the
    // quotient is forced to all ones.
    quo_s       = divZero_r ? {WIDTH{1'b1}} : (negRes_r ? negate(coreLo_s) : coreLo_s);
    rem_s       = negRem_r ? negate(coreHi_s) : coreHi_s;
    commitVal_s = isDivOp(op_r) ? {rem_s, quo_s} : mulResult_s;
  end

  // FSM state, counter and latched operation attributes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= S_IDLE;
      count_r   <= {CW{1'b0}};
      op_r      <= 3'd0;
      negRes_r  <= 1'b0;
      negRem_r  <= 1'b0;
      divZero_r <= 1'b0;
    end else begin
      state_r <= nextState_s;
      if (loadCore_s) begin
        count_r   <= {CW{1'b0}};
        op_r      <= bus.Op;
        negRes_r  <= signA_s ^ signB_s;
        negRem_r  <= signA_s;
        divZero_r <= (bus.B == {WIDTH{1'b0}});
      end else if (stepCore_s) begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  // Architectural Hi/Lo registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (moveHi_s) begin
      hi_r <= bus.A;
    end else if (moveLo_s) begin
      lo_r <= bus.A;
    end else if (commit_s) begin
      {hi_r, lo_r} <= commitVal_s;
    end
  end

  // Registered status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (nextState_s != S_IDLE);
      done_r <= commit_s;
    end
  end

  assign bus.Hi    = hi_r;
  assign bus.Lo    = lo_r;
  assign bus.Busy  = busy_r;
  assign bus.Done  = done_r;
  assign bus.Stall = busy_r & (bus.Start | bus.ReadHiLo);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;

  logic clk;
  logic rstN;

  hilo_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset_n (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    bit          isMove;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  // Runs 36 cycles after an issue; index i is the sample after edge E(i).
  task automatic observe(output int busyCnt, output int doneCnt, output int doneIdx);
    busyCnt = 0;
    doneCnt = 0;
    doneIdx = -1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 0) bus.Start = 1'b0;
      #1;
      if (bus.Busy === 1'b1) busyCnt++;
      if (bus.Done === 1'b1) begin
        doneCnt++;
        doneIdx = i;
      end
    end
  endtask

  initial begin
    int bc, dc, di, bad;
    logic [31:0] keepHi, keepLo;

    vecs[0]  = '{"multu_max",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{"mult_neg",    3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{"madd_wrap",   3'd4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[3]  = '{"msub_wrap",   3'd5, 32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[4]  = '{"div_neg",     3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"divu_zero",   3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{"divu_basic",  3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[8]  = '{"div_negb",    3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{"mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{"div_zero_s",  3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{"mthi",        3'd6, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{"mtlo",        3'd7, 32'h0000_1234, 32'h0000_0000, 32'hCAFE_BABE, 32'h0000_1234, 1'b1};

    rstN         = 1'b0;
    bus.Start    = 1'b0;
    bus.Op       = 3'd0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    bus.Abort    = 1'b0;
    bus.ReadHiLo = 1'b0;
    #3;
    check("reset_hi", bus.Hi, 32'd0);
    check("reset_lo", bus.Lo, 32'd0);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_done", {31'd0, bus.Done}, 32'd0);
    check("reset_stall", {31'd0, bus.Stall}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Table-driven operations; each one starts from the previous result.
    for (int v = 0; v < NV; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b);
      observe(bc, dc, di);
      check({vecs[v].name, "_busy_cycles"}, bc, vecs[v].isMove ? 32'd0 : 32'd33);
      check({vecs[v].name, "_done_pulses"}, dc, vecs[v].isMove ? 32'd0 : 32'd1);
      if (!vecs[v].isMove) check({vecs[v].name, "_done_index"}, di, 32'd33);
      check({vecs[v].name, "_hi"}, bus.Hi, vecs[v].expHi);
      check({vecs[v].name, "_lo"}, bus.Lo, vecs[v].expLo);
    end

    // MTLO lands one edge later without Busy.
    issue(3'd7, 32'h0000_5678, 32'd0);
    @(negedge clk);
    bus.Start = 1'b0;
    #1;
    check("mtlo_one_edge", bus.Lo, 32'h0000_5678);
    check("mtlo_no_busy", {31'd0, bus.Busy}, 32'd0);
    issue(3'd7, 32'h0000_1234, 32'd0);
    @(negedge clk);
    bus.Start = 1'b0;

    // Hazards: ReadHiLo and a second Start held during a DIV.
    issue(3'd2, 32'h0000_0064, 32'h0000_0007);
    bc = 0; dc = 0; di = -1; bad = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 0) begin
        issue(3'd1, 32'h0000_0002, 32'h0000_0003);
        bus.ReadHiLo = 1'b1;
      end
      #1;
      if (bus.Busy === 1'b1) begin
        bc++;
        if (bus.Stall !== 1'b1) bad++;
      end
      if (bus.Done === 1'b1) begin
        dc++;
        di = i;
        check("haz_stall_done", {31'd0, bus.Stall}, 32'd0);
        check("haz_hi_done", bus.Hi, 32'h0000_0002);
        check("haz_lo_done", bus.Lo, 32'h0000_000E);
        bus.Start    = 1'b0;
        bus.ReadHiLo = 1'b0;
      end
    end
    bus.Start    = 1'b0;
    bus.ReadHiLo = 1'b0;
    check("haz_stall_busy", bad, 32'd0);
    check("haz_busy_cycles", bc, 32'd33);
    check("haz_done_index", di, 32'd33);
    check("haz_busy_after", {31'd0, bus.Busy}, 32'd0);
    check("haz_lo_after", bus.Lo, 32'h0000_000E);
    keepHi = 32'h0000_0002;
    keepLo = 32'h0000_000E;

    // Abort mid-CALC.
    @(negedge clk);
    issue(3'd0, 32'h0000_0003, 32'h0000_0004);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) bus.Start = 1'b0;
    end
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    #1;
    check("abort_calc_busy", {31'd0, bus.Busy}, 32'd0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) dc++;
    end
    check("abort_calc_done", dc, 32'd0);
    check("abort_calc_hi", bus.Hi, keepHi);
    check("abort_calc_lo", bus.Lo, keepLo);

    // Abort while in FIXUP: no commit.
    issue(3'd1, 32'h0000_0003, 32'h0000_0004);
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i == 0) bus.Start = 1'b0;
    end
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    #1;
    check("abort_fix_done", {31'd0, bus.Done}, 32'd0);
    check("abort_fix_busy", {31'd0, bus.Busy}, 32'd0);
    check("abort_fix_lo", bus.Lo, keepLo);

    // Abort together with MTLO in IDLE: nothing written.
    issue(3'd7, 32'h0000_DEAD, 32'd0);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    #1;
    check("abort_mtlo_lo", bus.Lo, keepLo);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    issue(3'd0, 32'h0000_0003, 32'h0000_0004);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.Start = 1'b0;
    end
    #1;
    check("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("midreset_hi", bus.Hi, 32'd0);
    check("midreset_lo", bus.Lo, 32'd0);
    check("midreset_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) dc++;
    end
    check("postreset_quiet", dc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle controller for the Hi/Lo multiply/divide resource in the Execute stage.
- Accepts one MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO operation at a time.
- Runs an iterative shift-add multiply or restoring divide, then commits the result to its internal Hi/Lo registers.
- Drives Stall so the pipeline holds MFHI/MFLO, and any new Hi/Lo op, while a computation is in flight.

Parameters:
- WIDTH, 32, operand width and iteration count; Hi and Lo are each WIDTH bits.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled on the Clk rising edge.
- Op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- A  input  WIDTH  rs operand (dividend / multiplicand / move source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- Abort  input  1  pipeline flush; cancels the in-flight operation.
- ReadHiLo  input  1  instruction in Execute is MFHI/MFLO.
- Hi  output  WIDTH  Hi register.
- Lo  output  WIDTH  Lo register.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse; the cycle Hi/Lo first shows a new multi-cycle result.
- Stall  output  1  combinational: Busy & (Start | ReadHiLo).

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, operand regs=0. Reset mid-operation discards the operation with no Done.
- States: IDLE, CALC, FIXUP.
- IDLE, Start=1, Abort=0, Op=6/7: Hi (or Lo) <= A at that edge. Stay IDLE, no Busy, no Done.
- IDLE, Start=1, Abort=0, Op=0..5: latch operands and op, counter<=0, go to CALC.
  - Signed ops (MULT/DIV/MADD/MSUB) latch absolute values plus result-sign flags.
- CALC: one iteration per cycle, counter increments. After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIXUP.
- FIXUP: apply the sign correction and commit at the edge, then go to IDLE. Done=1 for exactly the following cycle.
- Latency: with the accept edge as E0, Hi/Lo are updated at edge E(WIDTH+1). Busy is high for WIDTH+1 cycles.
- Multiply results:
  - MULT/MULTU: {Hi,Lo} = A*B (signed/unsigned), full 2*WIDTH bits.
  - MADD: {Hi,Lo} += signed A*B, modulo 2^(2*WIDTH).
  - MSUB: {Hi,Lo} -= signed A*B, modulo 2^(2*WIDTH).
  - The accumulation uses the Hi/Lo value at FIXUP.
- Divide results:
  - Lo=quotient, Hi=remainder.
  - Signed: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - B==0: Lo=all ones, Hi=A, same latency, no exception.
  - Signed overflow (min / -1): Lo=min (0x80000000), Hi=0.
- Start while Busy: ignored (not queued). Stall is high, so the pipeline re-presents it after Done.
- ReadHiLo while Busy: Stall=1. In the Done cycle Stall=0 and Hi/Lo already hold the new value.
- Abort:
  - Any state: next edge goes to IDLE, Hi/Lo unchanged, no Done.
  - Abort and Start together in IDLE: Abort wins, nothing accepted (MTHI/MTLO not written).
  - Abort in FIXUP: no commit.
- Busy and Done are registered. Stall is the only combinational output.

Decomposition:
- Shared package holds:
  - op code constants (OP_MULT..OP_MTLO);
  - state encoding (S_IDLE, S_CALC, S_FIXUP);
  - a helper giving the counter width, clog2(WIDTH).
- One natural sub-module, muldiv_iter_core:
  - holds the partial product/remainder and quotient shift registers;
  - performs one shift-add or one restoring-subtract step per enable.
- The parent holds the FSM, counter, sign flags, Hi/Lo registers and Stall logic.

Test Plan:
- MULTU: A=0xFFFFFFFF, B=0x00000002 -> after 33 cycles Hi=0x00000001, Lo=0xFFFFFFFE; Done high exactly one cycle; Busy high exactly 33 cycles.
- MULT then MADD:
  - MULT A=-3, B=7 gives {Hi,Lo}=0xFFFFFFFF_FFFFFFEB.
  - MADD A=5, B=5 then gives Hi=0x00000000, Lo=0x00000004.
- DIV:
  - A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
  - DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000007.
  - DIV A=0x80000000, B=-1 -> Lo=0x80000000, Hi=0.
- Hazards:
  - During a DIV, assert ReadHiLo and a second Start -> Stall=1 every Busy cycle.
  - Second Start is not accepted.
  - Stall=0 in the Done cycle, and Hi/Lo show the DIV result.
- Abort/reset:
  - MTLO A=0x1234 -> Lo=0x1234 one edge later, Busy never high.
  - Start MULT, Abort at cycle 10 -> IDLE next edge, Hi/Lo unchanged, no Done.
  - Start MULT, drop Reset_n at cycle 20 (between clock edges) -> all outputs 0 immediately.
